// File: rtl/id_decode_pipe_pkg.sv
// Shared decode constants for the ID stage: opcode/func codes, ALU op/sel codes
// and the control record produced by instruction decode.
package id_decode_pipe_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam logic [4:0] LINK_REG = 5'd31;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'h24;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'h25;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'h26;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'h2A;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'h2B;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'h7C;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_ADDI_OP  = 8'h55;
    localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'h56;
    localparam logic [ALUOP_W-1:0] EXE_JUMP_OP  = 8'h4F;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP    = 8'hE3;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP         = 3'd0;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC       = 3'd1;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT       = 3'd2;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC  = 3'd4;
    localparam logic [ALUSEL_W-1:0] EXE_RES_JUMP_BRANCH = 3'd6;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE  = 3'd7;

    typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JR} br_e;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [4:0]          wd;
        logic                wreg;
        logic                re1;
        logic                re2;
        logic                link;
        logic                illegal;
        br_e                 br;
    } dec_t;

endpackage

// File: rtl/id_operand_fwd.sv
// Operand select for one register read port: zero register, priority
// forwarding (lowest index wins), register file, or immediate.
module id_operand_fwd #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                          re,
    input  logic [4:0]                    addr,
    input  logic [XLEN-1:0]               rf_data,
    input  logic [XLEN-1:0]               imm,
    input  logic [NUM_FWD-1:0]            fwd_wreg,
    input  logic [NUM_FWD-1:0][4:0]       fwd_wd,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_wdata,
    output logic [XLEN-1:0]               data
);

    always_comb begin
        data = rf_data;
        // Walk oldest to youngest so the youngest match overwrites.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wreg[i] && fwd_wd[i] == addr)
                data = fwd_wdata[i];
        end
        if (!re)
            data = imm;
        else if (addr == 5'd0)
            data = '0;
    end

endmodule

// File: rtl/id_decode_pipe.sv
// Registered ID stage with valid/ready handshake, forwarding, load-use stall,
// branch/jump resolution, delay-slot tracking and illegal-opcode flagging.
module id_decode_pipe
    import id_decode_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [31:0]                   in_inst,
    output logic [4:0]                    reg1_addr_o,
    output logic [4:0]                    reg2_addr_o,
    input  logic [XLEN-1:0]               reg1_data_i,
    input  logic [XLEN-1:0]               reg2_data_i,
    input  logic [NUM_FWD-1:0]            fwd_wreg_i,
    input  logic [NUM_FWD-1:0][4:0]       fwd_wd_i,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_wdata_i,
    input  logic                          ex_is_load_i,
    input  logic                          flush_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ALUOP_W-1:0]            aluop_o,
    output logic [ALUSEL_W-1:0]           alusel_o,
    output logic [XLEN-1:0]               reg1_o,
    output logic [XLEN-1:0]               reg2_o,
    output logic [4:0]                    wd_o,
    output logic                          wreg_o,
    output logic [XLEN-1:0]               link_addr_o,
    output logic                          is_in_delayslot_o,
    output logic                          illegal_o,
    output logic                          branch_flag_o,
    output logic [XLEN-1:0]               branch_target_o,
    output logic [STALL_CNT_W-1:0]        stall_cycles_o
);

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm16;
    dec_t        dec;
    logic [XLEN-1:0] imm, opnd1, opnd2, pc_plus4, pc_plus8;
    logic        hazard, accept, taken, next_in_delayslot;

    assign op    = in_inst[31:26];
    assign rs    = in_inst[25:21];
    assign rt    = in_inst[20:16];
    assign rd    = in_inst[15:11];
    assign sh    = in_inst[10:6];
    assign fn    = in_inst[5:0];
    assign imm16 = in_inst[15:0];

    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;
    assign pc_plus4    = in_pc + XLEN'(4);
    assign pc_plus8    = in_pc + XLEN'(8);

    always_comb begin
        dec = '0;
        dec.illegal = 1'b1;
        imm = '0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADD, FN_ADDU,
                    FN_SUB, FN_SUBU, FN_SLT, FN_SLTU: begin
                        // These ALU op codes are the func code with two leading zeros.
                        dec.aluop   = {2'b00, fn};
                        dec.alusel  = (fn[5:2] == 4'b1001) ? EXE_RES_LOGIC : EXE_RES_ARITHMETIC;
                        dec.re1     = 1'b1;
                        dec.re2     = 1'b1;
                        dec.wreg    = 1'b1;
                        dec.wd      = rd;
                        dec.illegal = (sh != 5'd0);
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.aluop   = (fn == FN_SLL) ? EXE_SLL_OP :
                                      (fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                        dec.alusel  = EXE_RES_SHIFT;
                        dec.re2     = 1'b1;
                        dec.wreg    = 1'b1;
                        dec.wd      = rd;
                        dec.illegal = (rs != 5'd0);
                        imm         = XLEN'(sh);
                    end
                    FN_JR: begin
                        dec.aluop   = EXE_JUMP_OP;
                        dec.alusel  = EXE_RES_JUMP_BRANCH;
                        dec.re1     = 1'b1;
                        dec.br      = BR_JR;
                        dec.illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                dec.aluop   = (op == OP_ANDI) ? EXE_AND_OP :
                              (op == OP_XORI) ? EXE_XOR_OP : EXE_OR_OP;
                dec.alusel  = EXE_RES_LOGIC;
                dec.re1     = 1'b1;
                dec.wreg    = 1'b1;
                dec.wd      = rt;
                dec.illegal = 1'b0;
                imm         = (op == OP_LUI) ? XLEN'({imm16, 16'h0000}) : XLEN'(imm16);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                dec.aluop   = (op == OP_ADDI)  ? EXE_ADDI_OP  :
                              (op == OP_ADDIU) ? EXE_ADDIU_OP :
                              (op == OP_SLTI)  ? EXE_SLT_OP   :
                              (op == OP_SLTIU) ? EXE_SLTU_OP  : EXE_LW_OP;
                dec.alusel  = (op == OP_LW) ? EXE_RES_LOAD_STORE : EXE_RES_ARITHMETIC;
                dec.re1     = 1'b1;
                dec.wreg    = 1'b1;
                dec.wd      = rt;
                dec.illegal = 1'b0;
                imm         = XLEN'($signed(imm16));
            end
            OP_BEQ, OP_BNE: begin
                dec.aluop   = EXE_JUMP_OP;
                dec.alusel  = EXE_RES_JUMP_BRANCH;
                dec.re1     = 1'b1;
                dec.re2     = 1'b1;
                dec.br      = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
                dec.illegal = 1'b0;
            end
            OP_J, OP_JAL: begin
                dec.aluop   = EXE_JUMP_OP;
                dec.alusel  = EXE_RES_JUMP_BRANCH;
                dec.br      = BR_J;
                dec.wreg    = (op == OP_JAL);
                dec.wd      = (op == OP_JAL) ? LINK_REG : 5'd0;
                dec.link    = (op == OP_JAL);
                dec.illegal = 1'b0;
            end
            default: ;
        endcase
        // Anything undecodable collapses to a NOP that still flows down the pipe.
        if (dec.illegal) begin
            dec = '0;
            dec.illegal = 1'b1;
            imm = '0;
        end
    end

    id_operand_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
        .re(dec.re1), .addr(rs), .rf_data(reg1_data_i), .imm(imm),
        .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(opnd1)
    );

    id_operand_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
        .re(dec.re2), .addr(rt), .rf_data(reg2_data_i), .imm(imm),
        .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(opnd2)
    );

    assign hazard = ex_is_load_i & fwd_wreg_i[0] & (fwd_wd_i[0] != 5'd0) &
                    ((dec.re1 & (fwd_wd_i[0] == rs)) | (dec.re2 & (fwd_wd_i[0] == rt)));
    assign in_ready = !flush_i & !hazard & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        taken = 1'b0;
        branch_target_o = '0;
        case (dec.br)
            BR_BEQ: begin
                taken = (opnd1 == opnd2);
                branch_target_o = pc_plus4 + (XLEN'($signed(imm16)) << 2);
            end
            BR_BNE: begin
                taken = (opnd1 != opnd2);
                branch_target_o = pc_plus4 + (XLEN'($signed(imm16)) << 2);
            end
            BR_J: begin
                taken = 1'b1;
                branch_target_o = {pc_plus4[XLEN-1:28], in_inst[25:0], 2'b00};
            end
            BR_JR: begin
                taken = 1'b1;
                branch_target_o = opnd1;
            end
            default: ;
        endcase
    end

    assign branch_flag_o = accept & taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid         <= 1'b0;
            aluop_o           <= '0;
            alusel_o          <= '0;
            reg1_o            <= '0;
            reg2_o            <= '0;
            wd_o              <= '0;
            wreg_o            <= 1'b0;
            link_addr_o       <= '0;
            is_in_delayslot_o <= 1'b0;
            illegal_o         <= 1'b0;
            next_in_delayslot <= 1'b0;
            stall_cycles_o    <= '0;
        end else begin
            if (flush_i) begin
                out_valid         <= 1'b0;
                next_in_delayslot <= 1'b0;
            end else if (accept) begin
                out_valid         <= 1'b1;
                aluop_o           <= dec.aluop;
                alusel_o          <= dec.alusel;
                reg1_o            <= opnd1;
                reg2_o            <= opnd2;
                wd_o              <= dec.wd;
                wreg_o            <= dec.wreg;
                link_addr_o       <= dec.link ? pc_plus8 : '0;
                is_in_delayslot_o <= next_in_delayslot;
                illegal_o         <= dec.illegal;
                next_in_delayslot <= (dec.br != BR_NONE);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && !flush_i && !(&stall_cycles_o))
                stall_cycles_o <= stall_cycles_o + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: hand-computed vectors checked with
// a checking task; stall counter narrowed so saturation is reachable.
module tb_id_decode_pipe;

    localparam int XLEN = 32;
    localparam int NF   = 2;
    localparam int SCW  = 4;

    logic clk, rst, in_valid, in_ready, ex_is_load_i, flush_i, out_valid, out_ready;
    logic [XLEN-1:0] in_pc, reg1_data_i, reg2_data_i, reg1_o, reg2_o, link_addr_o, branch_target_o;
    logic [31:0] in_inst;
    logic [4:0] reg1_addr_o, reg2_addr_o, wd_o;
    logic [NF-1:0] fwd_wreg_i;
    logic [NF-1:0][4:0] fwd_wd_i;
    logic [NF-1:0][XLEN-1:0] fwd_wdata_i;
    logic [7:0] aluop_o;
    logic [2:0] alusel_o;
    logic wreg_o, is_in_delayslot_o, illegal_o, branch_flag_o;
    logic [SCW-1:0] stall_cycles_o;
    int errors = 0;
    int checks = 0;

    id_decode_pipe #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
        .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .ex_is_load_i(ex_is_load_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o),
        .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .link_addr_o(link_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .illegal_o(illegal_o), .branch_flag_o(branch_flag_o),
        .branch_target_o(branch_target_o), .stall_cycles_o(stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        reg1_data_i = '0; reg2_data_i = '0; fwd_wreg_i = '0; fwd_wd_i = '0;
        fwd_wdata_i = '0; ex_is_load_i = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stall", stall_cycles_o, 4'd0);
        chk("rst_illegal", illegal_o, 1'b0);
        chk("rst_ds", is_in_delayslot_o, 1'b0);
        chk("rst_wreg", wreg_o, 1'b0);

        rst = 1'b0; in_valid = 1'b1; in_inst = 32'h34028000;
        reg1_data_i = 32'hDEAD; reg2_data_i = 32'hBEEF;
        #1 chk("ori_in_ready", in_ready, 1'b1);
        tick();
        chk("ori_valid", out_valid, 1'b1);
        chk("ori_reg1", reg1_o, 32'h0);
        chk("ori_reg2", reg2_o, 32'h00008000);
        chk("ori_wd", wd_o, 5'd2);
        chk("ori_wreg", wreg_o, 1'b1);
        chk("ori_aluop", aluop_o, 8'h25);
        chk("ori_alusel", alusel_o, 3'd1);

        in_inst = 32'h2023FFFF; fwd_wreg_i = 2'b11;
        fwd_wd_i[0] = 5'd1; fwd_wd_i[1] = 5'd1;
        fwd_wdata_i[0] = 32'h10; fwd_wdata_i[1] = 32'h20;
        tick();
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_reg1", reg1_o, 32'h10);
        chk("addi_reg2", reg2_o, 32'hFFFFFFFF);
        chk("addi_wd", wd_o, 5'd3);

        in_inst = 32'h00842821; ex_is_load_i = 1'b1; fwd_wreg_i = 2'b01;
        fwd_wd_i[0] = 5'd4; fwd_wd_i[1] = 5'd0; fwd_wdata_i[0] = 32'h77;
        #1 chk("lu_in_ready", in_ready, 1'b0);
        chk("lu_raddr1", reg1_addr_o, 5'd4);
        chk("lu_raddr2", reg2_addr_o, 5'd4);
        tick();
        chk("lu_stall", stall_cycles_o, 4'd1);
        chk("lu_drain", out_valid, 1'b0);
        ex_is_load_i = 1'b0; fwd_wreg_i = 2'b10; fwd_wd_i[0] = 5'd0;
        fwd_wd_i[1] = 5'd4; fwd_wdata_i[1] = 32'h44;
        #1 chk("lu_release", in_ready, 1'b1);
        tick();
        chk("lu_valid", out_valid, 1'b1);
        chk("lu_reg1", reg1_o, 32'h44);
        chk("lu_reg2", reg2_o, 32'h44);
        chk("lu_wd", wd_o, 5'd5);
        chk("lu_stall_hold", stall_cycles_o, 4'd1);

        fwd_wreg_i = '0; reg1_data_i = 32'd5; reg2_data_i = 32'd5;
        in_pc = 32'h100; in_inst = 32'h10210003;
        #1 chk("beq_flag", branch_flag_o, 1'b1);
        chk("beq_target", branch_target_o, 32'h110);
        tick();
        chk("beq_aluop", aluop_o, 8'h4F);
        chk("beq_wreg", wreg_o, 1'b0);
        in_pc = 32'h104; in_inst = 32'h34060001;
        #1 chk("slot_flag", branch_flag_o, 1'b0);
        tick();
        chk("slot_ds", is_in_delayslot_o, 1'b1);
        chk("slot_wd", wd_o, 5'd6);
        in_pc = 32'h108; in_inst = 32'h34070002;
        tick();
        chk("after_ds", is_in_delayslot_o, 1'b0);

        in_pc = 32'h10C; in_inst = 32'h14210003;
        #1 chk("bne_flag", branch_flag_o, 1'b0);
        tick();
        in_pc = 32'h200; in_inst = 32'h0C000040;
        #1 chk("jal_flag", branch_flag_o, 1'b1);
        chk("jal_target", branch_target_o, 32'h100);
        tick();
        chk("jal_ds", is_in_delayslot_o, 1'b1);
        chk("jal_wd", wd_o, 5'd31);
        chk("jal_link", link_addr_o, 32'h208);
        chk("jal_wreg", wreg_o, 1'b1);

        out_ready = 1'b0; in_pc = 32'h204; in_inst = 32'h34080003;
        #1 chk("hold_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_wd", wd_o, 5'd31);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        chk("hold_stall", stall_cycles_o, 4'd1);
        flush_i = 1'b1;
        #1 chk("flush_flag", branch_flag_o, 1'b0);
        tick();
        chk("flush_valid", out_valid, 1'b0);
        flush_i = 1'b0; out_ready = 1'b1;
        tick();
        chk("postflush_valid", out_valid, 1'b1);
        chk("postflush_ds", is_in_delayslot_o, 1'b0);
        chk("postflush_wd", wd_o, 5'd8);

        in_inst = 32'h00024900; reg2_data_i = 32'hAB;
        tick();
        chk("sll_reg1", reg1_o, 32'h4);
        chk("sll_reg2", reg2_o, 32'hAB);
        chk("sll_aluop", aluop_o, 8'h7C);
        chk("sll_alusel", alusel_o, 3'd2);
        in_inst = 32'h00224900;
        tick();
        chk("sllrs_illegal", illegal_o, 1'b1);
        chk("sllrs_wreg", wreg_o, 1'b0);
        in_inst = 32'hFC000000;
        tick();
        chk("op3f_valid", out_valid, 1'b1);
        chk("op3f_illegal", illegal_o, 1'b1);
        chk("op3f_wreg", wreg_o, 1'b0);
        chk("op3f_aluop", aluop_o, 8'h00);

        in_inst = 32'h00842821; ex_is_load_i = 1'b1; fwd_wreg_i = 2'b01;
        fwd_wd_i[0] = 5'd4;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_stall", stall_cycles_o, 4'hF);
        chk("sat_in_ready", in_ready, 1'b0);
        chk("sat_valid", out_valid, 1'b0);

        ex_is_load_i = 1'b0; fwd_wreg_i = '0; in_inst = 32'h34028000;
        tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_stall", stall_cycles_o, 4'd0);
        chk("mrst_wd", wd_o, 5'd0);
        chk("mrst_reg2", reg2_o, 32'h0);
        chk("mrst_illegal", illegal_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
